// File: rtl/rgbled_pkg.sv
// Shared types and default timing constants for the RGB LED frame controller.
package rgbled_pkg;

    localparam int DEF_LEDS           = 8;
    localparam int DEF_BITS_PER_LED   = 24;
    localparam int DEF_LATCH_CYCLES   = 4000;
    localparam int DEF_REFRESH_CYCLES = 2000000;
    localparam int DEF_TIMEOUT_CYCLES = 65536;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_LATCH
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rgbled_sync_edge.sv
// Two-flop synchroniser for the asynchronous frame-ready level, followed by a rising-edge detector.
module rgbled_sync_edge (
    input  logic clk,
    input  logic nreset,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/rgbled_frame_ctrl.sv
// Frame controller: buffers frames from the SPI receiver, hands them to the LED driver,
// enforces the latch gap and periodically re-sends the last frame.
module rgbled_frame_ctrl
    import rgbled_pkg::*;
#(
    parameter int LEDS           = DEF_LEDS,
    parameter int BITS_PER_LED   = DEF_BITS_PER_LED,
    parameter int LATCH_CYCLES   = DEF_LATCH_CYCLES,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic [LEDS*BITS_PER_LED-1:0] spi_data,
    input  logic                         spi_rdy,
    output logic [LEDS*BITS_PER_LED-1:0] drv_data,
    output logic                         drv_start,
    input  logic                         drv_done,
    output logic                         busy,
    output logic [7:0]                   frames_sent,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int FRAME_W = LEDS * BITS_PER_LED;
    localparam int CNT_MAX = max3(LATCH_CYCLES, REFRESH_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic rdy_evt;

    rgbled_sync_edge u_sync_edge (
        .clk   (clk),
        .nreset(nreset),
        .d_i   (spi_rdy),
        .rise_o(rdy_evt)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [FRAME_W-1:0]   drv_data_q, drv_data_d;
    logic                 pending_q, pending_d;
    logic                 have_frame_q, have_frame_d;
    logic [7:0]           frames_q, frames_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shadow_q     <= '0;
            drv_data_q   <= '0;
            pending_q    <= 1'b0;
            have_frame_q <= 1'b0;
            frames_q     <= 8'd0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            drv_data_q   <= drv_data_d;
            pending_q    <= pending_d;
            have_frame_q <= have_frame_d;
            frames_q     <= frames_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    // One counter serves refresh (IDLE), timeout (SEND) and latch gap (LATCH).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        drv_data_d   = drv_data_q;
        pending_d    = pending_q | rdy_evt;
        have_frame_d = have_frame_q | rdy_evt;
        frames_d     = frames_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        // A pending frame is only lost if LOAD is not consuming it this same cycle.
        if (rdy_evt) begin
            shadow_d = spi_data;
            if (pending_q && (state_q != ST_LOAD)) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (have_frame_q) begin
                    if (cnt_q == REFRESH_LAST) begin
                        state_d = ST_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_LOAD: begin
                drv_data_d = shadow_q;
                pending_d  = rdy_evt;
                cnt_d      = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (drv_done) begin
                    frames_d = frames_q + 8'd1;
                    cnt_d    = '0;
                    state_d  = ST_LATCH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_LATCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign drv_data    = drv_data_q;
    assign drv_start   = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign frames_sent = frames_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rgbled_frame_ctrl.sv
// Self-checking bench for rgbled_frame_ctrl with a small chain and short timing parameters.
module tb_rgbled_frame_ctrl;

    localparam int LEDS    = 2;
    localparam int BPL     = 24;
    localparam int LATCH   = 8;
    localparam int REFRESH = 100;
    localparam int TIMEOUT = 64;
    localparam int FW      = LEDS * BPL;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic [FW-1:0] spi_data = '0;
    logic          spi_rdy = 1'b0;
    logic [FW-1:0] drv_data;
    logic          drv_start;
    logic          drv_done = 1'b0;
    logic          busy;
    logic [7:0]    frames_sent;
    logic          overrun;
    logic          timeout;

    rgbled_frame_ctrl #(
        .LEDS          (LEDS),
        .BITS_PER_LED  (BPL),
        .LATCH_CYCLES  (LATCH),
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .spi_data   (spi_data),
        .spi_rdy    (spi_rdy),
        .drv_data   (drv_data),
        .drv_start  (drv_start),
        .drv_done   (drv_done),
        .busy       (busy),
        .frames_sent(frames_sent),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [FW-1:0] expQ[$];
    bit            modelPending = 1'b0;
    logic [7:0]    expFrames = 8'd0;

    task automatic tick();
        @(negedge clk);
    endtask

    // Raising spi_rdy queues a frame; a second frame before the load replaces the queued one.
    task automatic raiseRdy(input logic [FW-1:0] frame);
        spi_data = frame;
        spi_rdy  = 1'b1;
        if (modelPending && (expQ.size() > 0)) expQ[expQ.size()-1] = frame;
        else expQ.push_back(frame);
        modelPending = 1'b1;
    endtask

    task automatic applyStimulus(input logic [FW-1:0] frame);
        raiseRdy(frame);
        repeat (3) tick();
        spi_rdy = 1'b0;
        repeat (3) tick();
    endtask

    task automatic driveDone();
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
    endtask

    // Sends a frame, waits (bounded) for drv_start, then returns what the driver sees one cycle later.
    task automatic loadFrame(input logic [FW-1:0] frame, output int lat,
                             output logic [FW-1:0] seen, output logic [FW-1:0] exp);
        raiseRdy(frame);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (drv_start === 1'b1) begin
                lat = i;
                break;
            end
        end
        spi_rdy = 1'b0;
        if (lat > 0) modelPending = 1'b0;
        tick();
        seen = drv_data;
        exp  = (expQ.size() > 0) ? expQ.pop_front() : '1;
    endtask

    task automatic test_reset();
        nreset  = 1'b0;
        spi_rdy = 1'b0;
        repeat (3) tick();
        total++;
        if ({drv_data, drv_start, busy, frames_sent, overrun, timeout} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got data=%h start=%b busy=%b frames=%0d ovr=%b to=%b want all 0",
                     drv_data, drv_start, busy, frames_sent, overrun, timeout);
        end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_idle_no_frame();
        int starts = 0;
        int busies = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) drv_done = 1'b1;
            tick();
            drv_done = 1'b0;
            if (drv_start !== 1'b0) starts++;
            if (busy !== 1'b0) busies++;
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("[TB] FAIL idle_no_start got=%0d starts want=0", starts);
        end
        total++;
        if (busies != 0) begin
            bad++;
            $display("[TB] FAIL idle_busy got=%0d busy cycles want=0", busies);
        end
        total++;
        if (frames_sent !== expFrames) begin
            bad++;
            $display("[TB] FAIL done_outside_send got=%0d want=%0d", frames_sent, expFrames);
        end
    endtask

    task automatic test_single();
        logic [FW-1:0] exp;
        int early = 0;
        raiseRdy(48'hAABBCC_112233);
        repeat (3) begin
            tick();
            if (drv_start !== 1'b0) early++;
        end
        tick();
        total++;
        if (early != 0 || drv_start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL start_latency got early=%0d start@4=%b want early=0 start@4=1", early, drv_start);
        end
        spi_rdy = 1'b0;
        modelPending = 1'b0;
        tick();
        exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
        total++;
        if (drv_data !== exp) begin
            bad++;
            $display("[TB] FAIL single_data got=%h want=%h", drv_data, exp);
        end
        repeat (5) tick();
        driveDone();
        expFrames++;
        total++;
        if (frames_sent !== expFrames) begin
            bad++;
            $display("[TB] FAIL single_count got=%0d want=%0d", frames_sent, expFrames);
        end
        repeat (7) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL latch_last_cycle busy got=%b want=1", busy);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL latch_exit busy got=%b want=0", busy);
        end
    endtask

    task automatic test_refresh();
        logic [FW-1:0] exp;
        int early = 0;
        expQ.push_back(48'hAABBCC_112233);
        for (int i = 1; i < REFRESH; i++) begin
            tick();
            if (drv_start !== 1'b0) early++;
        end
        tick();
        total++;
        if (early != 0 || drv_start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL refresh_timing got early=%0d start=%b want early=0 start=1", early, drv_start);
        end
        tick();
        exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
        total++;
        if (drv_data !== exp) begin
            bad++;
            $display("[TB] FAIL refresh_data got=%h want=%h", drv_data, exp);
        end
        driveDone();
        expFrames++;
        total++;
        if (frames_sent !== expFrames) begin
            bad++;
            $display("[TB] FAIL refresh_count got=%0d want=%0d", frames_sent, expFrames);
        end
        repeat (LATCH) tick();
    endtask

    task automatic test_overrun();
        localparam logic [FW-1:0] FA = 48'h0A0A0A_0A0A0A;
        localparam logic [FW-1:0] FB = 48'h0B0B0B_0B0B0B;
        logic [FW-1:0] seen, exp;
        int lat;
        int sawA = 0;
        loadFrame(48'h123456_789ABC, lat, seen, exp);
        total++;
        if (lat < 0 || seen !== exp) begin
            bad++;
            $display("[TB] FAIL ovr_first_frame got lat=%0d data=%h want data=%h", lat, seen, exp);
        end
        repeat (2) tick();
        applyStimulus(FA);
        applyStimulus(FB);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overrun_flag got=%b want=1", overrun);
        end
        driveDone();
        expFrames++;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (drv_data === FA) sawA++;
            if (drv_start === 1'b1) begin
                lat = i;
                break;
            end
        end
        modelPending = 1'b0;
        tick();
        if (drv_data === FA) sawA++;
        exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
        total++;
        if (lat < 0 || drv_data !== exp) begin
            bad++;
            $display("[TB] FAIL ovr_latest_wins got lat=%0d data=%h want data=%h", lat, drv_data, exp);
        end
        total++;
        if (sawA != 0) begin
            bad++;
            $display("[TB] FAIL ovr_dropped_frame got=%0d cycles with A want=0", sawA);
        end
        driveDone();
        expFrames++;
        total++;
        if (frames_sent !== expFrames) begin
            bad++;
            $display("[TB] FAIL ovr_count got=%0d want=%0d", frames_sent, expFrames);
        end
        repeat (LATCH) tick();
    endtask

    task automatic test_timeout();
        logic [FW-1:0] seen, exp;
        int lat;
        loadFrame(48'hDEADBE_EF0001, lat, seen, exp);
        total++;
        if (lat < 0 || seen !== exp) begin
            bad++;
            $display("[TB] FAIL to_frame got lat=%0d data=%h want data=%h", lat, seen, exp);
        end
        repeat (TIMEOUT - 1) tick();
        total++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_early got timeout=%b busy=%b want timeout=0 busy=1", timeout, busy);
        end
        tick();
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_flag got=%b want=1", timeout);
        end
        total++;
        if (frames_sent !== expFrames) begin
            bad++;
            $display("[TB] FAIL to_count got=%0d want=%0d", frames_sent, expFrames);
        end
        repeat (LATCH - 1) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_latch_busy got=%b want=1", busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || overrun !== 1'b1 || timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL to_latch_exit got busy=%b ovr=%b to=%b want busy=0 ovr=1 to=1", busy, overrun, timeout);
        end
    endtask

    task automatic test_reset_mid_send();
        logic [FW-1:0] seen, exp;
        int lat;
        int starts = 0;
        loadFrame(48'h55AA55_AA55AA, lat, seen, exp);
        repeat (3) tick();
        nreset = 1'b0;
        #1;
        total++;
        if ({drv_data, drv_start, busy, frames_sent, overrun, timeout} !== '0) begin
            bad++;
            $display("[TB] FAIL midsend_reset got data=%h start=%b busy=%b frames=%0d ovr=%b to=%b want all 0",
                     drv_data, drv_start, busy, frames_sent, overrun, timeout);
        end
        expQ.delete();
        modelPending = 1'b0;
        expFrames = 8'd0;
        repeat (2) tick();
        nreset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (drv_start !== 1'b0 || busy !== 1'b0) starts++;
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle got=%0d active cycles want=0", starts);
        end
        loadFrame(48'hC0FFEE_123123, lat, seen, exp);
        total++;
        if (lat != 4 || seen !== exp) begin
            bad++;
            $display("[TB] FAIL post_reset_frame got lat=%0d data=%h want lat=4 data=%h", lat, seen, exp);
        end
        driveDone();
        expFrames++;
        total++;
        if (frames_sent !== expFrames) begin
            bad++;
            $display("[TB] FAIL post_reset_count got=%0d want=%0d", frames_sent, expFrames);
        end
        repeat (LATCH) tick();
    endtask

    initial begin
        test_reset();
        test_idle_no_frame();
        test_single();
        test_refresh();
        test_overrun();
        test_timeout();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
